cap_sense_scanner: RTL and testbench

- Measurement front end for the 9-pad capacitive touch array.
- Drives the shared charge line, times how long each pad's input takes to read high, and publishes one 32-bit count per pad on a packed bus read by the processor's memory-mapped input path.
- It is the input-side, reader counterpart to the LED command output path.
- Counts are larger when a finger is on a pad; the low byte of each count also feeds the RNG seed.

---
 rtl/cap_sense_scanner.sv | 130 +++++++++++++
 tb/tb_cap_sense_scanner.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cap_sense_scanner.sv
// Capacitive pad scanner: discharges the shared charge line, then times how long each
// synchronized pad input takes to read high and publishes one count per pad.
module cap_sense_scanner #(
    parameter int NUM_SENSORS      = 9,
    parameter int COUNT_W          = 32,
    parameter int TIMEOUT          = 65535,
    parameter int DISCHARGE_CYCLES = 4096
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           scan_enable,
    input  logic [NUM_SENSORS-1:0]         sense_in,
    output logic                           drive_out,
    output logic [NUM_SENSORS*COUNT_W-1:0] readings,
    output logic                           readings_valid,
    output logic [NUM_SENSORS-1:0]         timed_out
);

    localparam int                 DIS_W     = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
    localparam logic [DIS_W-1:0]   DIS_LAST  = DIS_W'(DISCHARGE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] TIMEOUT_C = COUNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_DISCHARGE,
        ST_CHARGE,
        ST_PUBLISH
    } state_e;

    state_e                           state_q, state_d;
    logic [NUM_SENSORS-1:0]           sync_meta_q;
    logic [NUM_SENSORS-1:0]           s_sync_q;
    logic [DIS_W-1:0]                 dis_cnt_q, dis_cnt_d;
    logic [COUNT_W-1:0]               chg_cnt_q, chg_cnt_d;
    logic [NUM_SENSORS-1:0]           done_q, done_d;
    logic [COUNT_W-1:0]               cap_q [NUM_SENSORS];
    logic [COUNT_W-1:0]               cap_d [NUM_SENSORS];
    logic [NUM_SENSORS*COUNT_W-1:0]   readings_q, readings_d;
    logic [NUM_SENSORS-1:0]           timed_out_q, timed_out_d;
    logic                             drive_q;
    logic                             valid_q;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        dis_cnt_d   = dis_cnt_q;
        chg_cnt_d   = chg_cnt_q;
        done_d      = done_q;
        cap_d       = cap_q;
        readings_d  = readings_q;
        timed_out_d = timed_out_q;

        case (state_q)
            ST_DISCHARGE: begin
                if (dis_cnt_q == DIS_LAST) begin
                    if (scan_enable) begin
                        state_d   = ST_CHARGE;
                        chg_cnt_d = '0;
                        done_d    = '0;
                        for (int i = 0; i < NUM_SENSORS; i++) cap_d[i] = '0;
                    end
                end else begin
                    dis_cnt_d = dis_cnt_q + 1'b1;
                end
            end

            ST_CHARGE: begin
                // Captures made this cycle count toward completion and are published directly.
                done_d = done_q | s_sync_q;
                for (int i = 0; i < NUM_SENSORS; i++) begin
                    if (s_sync_q[i] && !done_q[i]) cap_d[i] = chg_cnt_q;
                end
                if ((&done_d) || (chg_cnt_q == TIMEOUT_C)) begin
                    state_d = ST_PUBLISH;
                    for (int i = 0; i < NUM_SENSORS; i++) begin
                        readings_d[i*COUNT_W +: COUNT_W] = done_d[i] ? cap_d[i] : TIMEOUT_C;
                    end
                    timed_out_d = ~done_d;
                end else begin
                    chg_cnt_d = chg_cnt_q + 1'b1;
                end
            end

            ST_PUBLISH: begin
                state_d   = ST_DISCHARGE;
                dis_cnt_d = '0;
            end

            default: begin
                state_d   = ST_DISCHARGE;
                dis_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the capture array is
    // small and is cleared on reset so a partial scan can never leak into a publish.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_DISCHARGE;
            sync_meta_q <= '0;
            s_sync_q    <= '0;
            dis_cnt_q   <= '0;
            chg_cnt_q   <= '0;
            done_q      <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) cap_q[i] <= '0;
            readings_q  <= '0;
            timed_out_q <= '0;
            drive_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_meta_q <= sense_in;
            s_sync_q    <= sync_meta_q;
            dis_cnt_q   <= dis_cnt_d;
            chg_cnt_q   <= chg_cnt_d;
            done_q      <= done_d;
            cap_q       <= cap_d;
            readings_q  <= readings_d;
            timed_out_q <= timed_out_d;
            drive_q     <= (state_d == ST_CHARGE);
            valid_q     <= (state_d == ST_PUBLISH);
        end
    end

    assign drive_out      = drive_q;
    assign readings       = readings_q;
    assign readings_valid = valid_q;
    assign timed_out      = timed_out_q;

endmodule

// File: tb/tb_cap_sense_scanner.sv
// Bench for cap_sense_scanner: drives pad rise times relative to CHARGE start and
// compares against a rise-time model (count = rise + 2 synchronizer cycles, capped at TIMEOUT).
module tb_cap_sense_scanner;

    localparam int NS = 9;
    localparam int CW = 32;
    localparam int TO = 100;
    localparam int DC = 8;
    localparam int NEVER = 1000;

    logic              clock = 1'b0;
    logic              reset;
    logic              scan_enable;
    logic [NS-1:0]     sense_in;
    logic              drive_out;
    logic [NS*CW-1:0]  readings;
    logic              readings_valid;
    logic [NS-1:0]     timed_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int            exp_rd [NS];
    logic [NS-1:0] exp_to;

    cap_sense_scanner #(
        .NUM_SENSORS      (NS),
        .COUNT_W          (CW),
        .TIMEOUT          (TO),
        .DISCHARGE_CYCLES (DC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .scan_enable    (scan_enable),
        .sense_in       (sense_in),
        .drive_out      (drive_out),
        .readings       (readings),
        .readings_valid (readings_valid),
        .timed_out      (timed_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int rd(input int i);
        return int'(readings[i*CW +: CW]);
    endfunction

    function automatic bit readings_match();
        bit ok = 1'b1;
        for (int i = 0; i < NS; i++) if (rd(i) !== exp_rd[i]) ok = 1'b0;
        return ok;
    endfunction

    // One full scan. rise[i] is the CHARGE cycle in which pad i's raw input goes high;
    // negative means raised before waiting for CHARGE, NEVER means it stays low.
    task automatic run_scan(input string name, input int rise[NS], input int drop_k,
                            input int exp_wait, output int pub_cyc, output int len);
        int   seen [NS];
        int   wait_n;
        int   k;
        int   k_end;
        int   max_seen;
        logic ended;
        pub_cyc = cyc;
        len     = 0;
        for (int i = 0; i < NS; i++) if (rise[i] < 0) sense_in[i] = 1'b1;
        wait_n = 0;
        while (drive_out !== 1'b1 && wait_n < DC + 200) begin
            tick();
            wait_n++;
        end
        checks++;
        if (drive_out !== 1'b1) begin
            failures++;
            $display("FAIL %s_start: drive_out=%b expected 1 within %0d cycles", name, drive_out, DC + 200);
        end else begin
            if (exp_wait >= 0) begin
                checks++;
                if (wait_n !== exp_wait) begin
                    failures++;
                    $display("FAIL %s_discharge_len: got %0d cycles expected %0d", name, wait_n, exp_wait);
                end
            end
            max_seen = 0;
            for (int i = 0; i < NS; i++) begin
                seen[i] = ((rise[i] < 0) ? -wait_n : rise[i]) + 2;
                if (seen[i] < 0) seen[i] = 0;
                exp_rd[i] = (seen[i] <= TO) ? seen[i] : TO;
                exp_to[i] = (seen[i] > TO);
                if (seen[i] > max_seen) max_seen = seen[i];
            end
            k_end = (max_seen < TO) ? max_seen : TO;

            k = 0;
            ended = 1'b0;
            while (!ended && k <= TO + 5) begin
                for (int i = 0; i < NS; i++) if (rise[i] == k) sense_in[i] = 1'b1;
                if (k == drop_k) scan_enable = 1'b0;
                tick();
                k++;
                if (drive_out !== 1'b1) ended = 1'b1;
            end
            len     = k;
            pub_cyc = cyc;
            checks++;
            if (!ended) begin
                failures++;
                $display("FAIL %s_end: CHARGE still running after %0d cycles", name, k);
            end
            checks++;
            if (len !== k_end + 1) begin
                failures++;
                $display("FAIL %s_charge_len: got %0d cycles expected %0d", name, len, k_end + 1);
            end
            checks++;
            if (readings_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s_valid: got %b expected 1", name, readings_valid);
            end
            for (int i = 0; i < NS; i++) begin
                checks++;
                if (rd(i) !== exp_rd[i]) begin
                    failures++;
                    $display("FAIL %s_pad%0d: got %0d expected %0d", name, i, rd(i), exp_rd[i]);
                end
            end
            checks++;
            if (timed_out !== exp_to) begin
                failures++;
                $display("FAIL %s_timed_out: got %b expected %b", name, timed_out, exp_to);
            end
            sense_in = '0;
            tick();
            checks++;
            if (readings_valid !== 1'b0 || drive_out !== 1'b0) begin
                failures++;
                $display("FAIL %s_after: valid=%b drive=%b expected 0 0", name, readings_valid, drive_out);
            end
        end
    endtask

    task automatic test_reset_hold();
        int bad = 0;
        reset = 1'b1;
        scan_enable = 1'b0;
        sense_in = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < NS; i++) exp_rd[i] = 0;
        exp_to = '0;
        checks++;
        if (drive_out !== 1'b0 || readings !== '0 || readings_valid !== 1'b0 || timed_out !== '0) begin
            failures++;
            $display("FAIL reset_state: drive=%b valid=%b timed_out=%b readings_nonzero=%b expected all 0",
                     drive_out, readings_valid, timed_out, |readings);
        end
        for (int n = 0; n < 50; n++) begin
            tick();
            if (drive_out !== 1'b0 || readings !== '0 || readings_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle_hold: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_single_pad();
        int r [NS];
        int p, l;
        for (int i = 0; i < NS; i++) r[i] = 5;
        r[3] = 20;
        scan_enable = 1'b1;
        run_scan("single_pad", r, -1, 1, p, l);
    endtask

    task automatic test_timeout();
        int r [NS];
        int p, l;
        for (int i = 0; i < NS; i++) r[i] = 0;
        r[8] = NEVER;
        run_scan("timeout", r, -1, DC, p, l);
    endtask

    task automatic test_stuck_high();
        int r [NS];
        int p, l;
        for (int i = 0; i < NS; i++) r[i] = 10 + 3 * i;
        r[0] = -1;
        run_scan("stuck_high", r, -1, DC, p, l);
    endtask

    task automatic test_back_to_back();
        int r [NS];
        int p1, l1, p2, l2;
        for (int i = 0; i < NS; i++) r[i] = 2 * i;
        run_scan("b2b_a", r, -1, DC, p1, l1);
        for (int i = 0; i < NS; i++) r[i] = 30 - i;
        run_scan("b2b_b", r, -1, DC, p2, l2);
        checks++;
        if (p2 - p1 !== DC + l2 + 1) begin
            failures++;
            $display("FAIL b2b_period: got %0d cycles expected %0d", p2 - p1, DC + l2 + 1);
        end
    endtask

    task automatic test_random();
        int r [NS];
        int p_prev, p, l, sel;
        p_prev = -1;
        for (int s = 0; s < 10; s++) begin
            for (int i = 0; i < NS; i++) begin
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      r[i] = -1;
                else if (sel == 1) r[i] = NEVER;
                else               r[i] = int'($urandom_range(0, 110));
            end
            run_scan("random", r, -1, DC, p, l);
            if (p_prev >= 0) begin
                checks++;
                if (p - p_prev !== DC + l + 1) begin
                    failures++;
                    $display("FAIL random_period: got %0d cycles expected %0d", p - p_prev, DC + l + 1);
                end
            end
            p_prev = p;
        end
    endtask

    task automatic test_reset_mid_charge();
        int r [NS];
        int p, l, n;
        for (int i = 0; i < NS; i++) r[i] = 4 + i;
        run_scan("pre_reset", r, -1, DC, p, l);
        n = 0;
        while (drive_out !== 1'b1 && n < DC + 20) begin
            tick();
            n++;
        end
        for (int k = 1; k <= 40; k++) tick();
        checks++;
        if (drive_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_inscan: drive=%b expected 1 at k=40", drive_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NS; i++) exp_rd[i] = 0;
        exp_to = '0;
        checks++;
        if (drive_out !== 1'b0 || readings !== '0 || timed_out !== '0 || readings_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: drive=%b valid=%b timed_out=%b readings_nonzero=%b expected all 0",
                     drive_out, readings_valid, timed_out, |readings);
        end
        for (int i = 0; i < NS; i++) r[i] = 12 - i;
        r[2] = -1;
        run_scan("post_reset", r, -1, DC, p, l);
    endtask

    task automatic test_enable_drop();
        int r [NS];
        int p, l, bad;
        for (int i = 0; i < NS; i++) r[i] = 15 + 2 * i;
        run_scan("enable_drop", r, 10, DC, p, l);
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (drive_out !== 1'b0 || readings_valid !== 1'b0 || !readings_match()) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL enable_idle: got %0d bad cycles expected 0", bad);
        end
        scan_enable = 1'b1;
        for (int i = 0; i < NS; i++) r[i] = 40 - 3 * i;
        run_scan("reenable", r, -1, 1, p, l);
    endtask

    initial begin
        reset = 1'b1;
        scan_enable = 1'b0;
        sense_in = '0;
        test_reset_hold();
        test_single_pad();
        test_timeout();
        test_stuck_high();
        test_back_to_back();
        test_random();
        test_reset_mid_charge();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
